// File: rtl/ram_sp_master_pkg.sv
// Shared state encoding and default bus widths for the single-port RAM master.
package ram_sp_master_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_ADDR = 2'd2,
    RD_DATA = 2'd3
  } state_t;
endpackage

// File: rtl/ram_sp_sr_sw.sv
// Single-port RAM with a synchronous read register and a shared tristate data bus.
module ram_sp_sr_sw
  import ram_sp_master_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  cs,
  input  logic                  we,
  input  logic                  oe
);
  logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q;

  assign data = (cs && oe && !we) ? rd_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (cs && we) mem[address] <= data;
    if (cs && !we && oe) rd_q <= mem[address];
  end
endmodule

// File: rtl/ram_sp_master.sv
// Request/response front end driving a synchronous-read single-port RAM over a shared bus.
module ram_sp_master
  import ram_sp_master_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [1:0]            dbg_state
);
  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // responses are single-cycle rsp_valid pulses in request order with no backpressure.
  state_t                state, nxt;
  logic                  accept, park_set, park_valid, data_phase;
  logic [ADDR_WIDTH-1:0] park_addr;
  logic [DATA_WIDTH-1:0] park_data, drv_data;

  assign accept    = req_valid && req_ready;
  assign park_set  = (state == RD_ADDR) && accept && req_we;
  assign mem_data  = mem_we ? drv_data : {DATA_WIDTH{1'bz}};
  assign dbg_state = state;

  always_comb begin
    nxt = IDLE;
    unique case (state)
      IDLE, WRITE: nxt = !accept ? IDLE : (req_we ? WRITE : RD_ADDR);
      // The RAM read register loads at the end of RD_ADDR, so the next cycle must keep oe high.
      RD_ADDR:     nxt = (accept && !req_we) ? RD_ADDR : RD_DATA;
      RD_DATA: begin
        if (park_valid) nxt = WRITE;
        else            nxt = !accept ? IDLE : (req_we ? WRITE : RD_ADDR);
      end
      default:     nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_oe      <= 1'b0;
      mem_address <= '0;
      drv_data    <= '0;
      req_ready   <= 1'b0;
      park_valid  <= 1'b0;
      park_addr   <= '0;
      park_data   <= '0;
      data_phase  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      state      <= nxt;
      mem_cs     <= (nxt != IDLE);
      mem_we     <= (nxt == WRITE);
      mem_oe     <= (nxt == RD_ADDR) || (nxt == RD_DATA);
      req_ready  <= !park_set;
      park_valid <= park_set;
      if (park_set) begin
        park_addr <= req_addr;
        park_data <= req_wdata;
      end
      if (park_valid) begin
        mem_address <= park_addr;
        drv_data    <= park_data;
      end else if (accept && !park_set) begin
        mem_address <= req_addr;
        if (req_we) drv_data <= req_wdata;
      end
      // The cycle after an address phase carries that read's data on the bus.
      data_phase <= (state == RD_ADDR);
      rsp_valid  <= data_phase;
      if (data_phase) rsp_rdata <= mem_data;
    end
  end
endmodule

// File: tb/tb_ram_sp_master.sv
// Randomized and directed bench for ram_sp_master against a RAM model and an array reference.
module tb_ram_sp_master;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [7:0] mem_address;
  wire  [7:0] mem_data;
  logic       mem_cs, mem_we, mem_oe;
  logic [1:0] dbg_state;

  ram_sp_master #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .dbg_state(dbg_state)
  );

  ram_sp_sr_sw #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) ram (
    .clk(clk), .address(mem_address), .data(mem_data),
    .cs(mem_cs), .we(mem_we), .oe(mem_oe)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model and scoreboard
  logic [7:0] model_mem [256];
  logic [7:0] exp_q[$];
  int         due_q[$];
  logic       exp_ready = 1'b0;
  logic       prev_rd = 1'b0;
  int         n_total = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic do_checks();
    logic exp_v;
    chk("ready", 32'(req_ready), 32'(exp_ready));
    chk("we_with_oe", 32'(mem_we && mem_oe), 32'd0);
    exp_v = (due_q.size() > 0) && (due_q[0] == cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
      void'(due_q.pop_front());
    end
  endtask

  // driver: called at a falling edge, presents inputs for the next rising edge
  task automatic tick(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d,
                      output logic acc);
    do_checks();
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    acc = v && req_ready;
    if (acc && we) model_mem[a] = d;
    if (acc && !we) begin
      exp_q.push_back(model_mem[a]);
      due_q.push_back(cyc + 3);
    end
    exp_ready = rst_n && !(acc && we && prev_rd);
    prev_rd = acc && !we;
    @(negedge clk);
  endtask

  task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 8) begin
      tick(1'b1, we, a, d, acc);
      tries++;
    end
    chk("send_accept", 32'(acc), 32'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 8'h00, acc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    chk({tag, "_cs"}, 32'(mem_cs), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_oe"}, 32'(mem_oe), 32'd0);
    chk({tag, "_addr"}, 32'(mem_address), 32'd0);
  endtask

  initial begin
    logic acc;
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    idle(2);

    // fill every location so all reads have a known reference value
    for (int i = 0; i < 256; i++) send(1'b1, 8'(i), 8'($urandom_range(0, 255)));
    idle(4);

    // single write then read with fixed latency
    send(1'b1, 8'h10, 8'hA5);
    send(1'b0, 8'h10, 8'h00);
    idle(5);

    // back-to-back writes then back-to-back reads
    send(1'b1, 8'h00, 8'h11); send(1'b1, 8'h01, 8'h22);
    send(1'b1, 8'h02, 8'h33); send(1'b1, 8'h03, 8'h44);
    for (int i = 0; i < 4; i++) send(1'b0, 8'(i), 8'h00);
    idle(6);

    // read followed by write to the same address: write parks, re-read sees new data
    send(1'b0, 8'h05, 8'h00);
    send(1'b1, 8'h05, 8'h5A);
    send(1'b0, 8'h05, 8'h00);
    idle(6);

    // quiet bus while idle
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 8'h00, 8'h00, acc);
      chk("idle_cs", 32'(mem_cs), 32'd0);
      chk("idle_bus_driven", 32'(mem_we || (mem_cs && mem_oe)), 32'd0);
    end

    // reset during the data phase of a read of 0x20
    send(1'b0, 8'h20, 8'h00);
    tick(1'b0, 1'b0, 8'h00, 8'h00, acc);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    due_q.delete();
    prev_rd = 1'b0;
    exp_ready = 1'b0;
    chk_reset_outputs("mid_rst");
    idle(3);
    chk_reset_outputs("hold_rst");
    rst_n = 1'b1;
    idle(2);
    send(1'b0, 8'h20, 8'h00);
    idle(5);

    // random traffic over a small address window to provoke hazards
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) < 7)
        tick(1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
             8'($urandom_range(0, 255)), acc);
      else
        tick(1'b0, 1'b0, 8'h00, 8'h00, acc);
    end
    idle(6);
    chk("rsp_queue_drained", 32'(due_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ram_sp_master.md
RAM_SP_MASTER -- requirements
Module: ram_sp_master

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bus width.
REQ-002 Parameter ADDR_WIDTH, default 8, address width.
REQ-003 Single clock and asynchronous active-low reset.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  request accepted when req_valid && req_ready at a rising edge.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_WIDTH  request address.
REQ-010 req_wdata  input  DATA_WIDTH  write data.
REQ-011 rsp_valid  output  1  one-cycle pulse, read data valid; no backpressure.
REQ-012 rsp_rdata  output  DATA_WIDTH  read data, held until next response.
REQ-013 mem_address  output  ADDR_WIDTH  RAM address, registered.
REQ-014 mem_data  inout  DATA_WIDTH  shared RAM data bus.
REQ-015 mem_cs, mem_we, mem_oe  output  1 each  RAM chip select, write enable, output enable, registered.

Function
REQ-016 Target RAM: write at rising edge when cs && we; read register loads at rising edge when cs && !we && oe; RAM drives the bus while cs && oe && !we.
REQ-017 States are IDLE, WRITE, RD_ADDR and RD_DATA; mem_* outputs are registered from next-state logic.
REQ-018 In IDLE: cs=0, we=0, oe=0, bus released (all Z), mem_address holds.
REQ-019 In WRITE: cs=1, we=1, oe=0, mem_data driven with the accepted wdata; the bus is driven only in WRITE.
REQ-020 In RD_ADDR and RD_DATA: cs=1, we=0, oe=1, bus released.
REQ-021 An accepted write enters WRITE in the next cycle, so back-to-back writes issue one per cycle.
REQ-022 An accepted read enters RD_ADDR in the next cycle with mem_address set to the read address.
REQ-023 The cycle after any RD_ADDR is that read's data phase; mem_data is captured into rsp_rdata at the end of the data phase, and rsp_valid is high in the following cycle.
REQ-024 Read latency: the address phase is cycle 1 after the accepting edge, the data phase is cycle 2, and rsp_valid is high in cycle 3.
REQ-025 A read accepted in RD_ADDR goes to RD_ADDR again, so that cycle is both the new address phase and the prior data phase; back-to-back reads give one response per cycle.
REQ-026 A write accepted in RD_ADDR is parked in a one-entry register, the next state is RD_DATA, then WRITE issues the parked data.
REQ-027 req_ready is 0 in RD_DATA while a write is parked, and 1 in all other states when out of reset.
REQ-028 From RD_DATA with no parked write: an accepted read goes to RD_ADDR, an accepted write goes to WRITE, otherwise IDLE.
REQ-029 From WRITE: a read goes to RD_ADDR, a write goes to WRITE, otherwise IDLE.
REQ-030 The bus is never driven by both ends: the controller drives only when we=1, and the RAM drives only when we=0.
REQ-031 Responses return in request order.

Reset
REQ-032 When rst_n is low: state IDLE, mem_cs/we/oe=0, mem_address=0, bus Z, rsp_valid=0, rsp_rdata=0, parked write cleared, req_ready=0.
REQ-033 Reset mid-operation discards in-flight reads and parked writes with no response; the first request after release is handled normally.

Structure
REQ-034 State encodings and default widths live in a shared header; no other file redefines them.
REQ-035 The block is flat; the response capture register is inline, and no sub-module is required.
REQ-036 The bench instantiates ram_sp_sr_sw (DATA_WIDTH=8, ADDR_WIDTH=8) as the memory model.

Verification
REQ-037 Write 0x10<=0xA5, then read 0x10 -> rsp_valid in cycle 3 after the read accept, rsp_rdata=0xA5.
REQ-038 Writes 0x00..0x03<=0x11..0x44 on consecutive cycles, then reads 0x00..0x03 back-to-back -> req_ready stays 1, and four consecutive rsp_valid pulses return 0x11,0x22,0x33,0x44.
REQ-039 Read 0x05 immediately followed by write 0x05<=0x5A -> read returns the old value, the write is parked, req_ready=0 for one cycle, a re-read returns 0x5A, and no cycle has we=1 with the RAM driving.
REQ-040 Idle for 10 cycles -> cs=0 and mem_data=Z throughout.
REQ-041 Assert rst_n low during the data phase of a read of 0x20 -> no rsp_valid, all outputs at reset values; after release, a read of 0x20 returns the stored value.
